// File: rtl/sdram_avalon_tester.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_avalon_tester
//  Purpose  : Avalon-MM master for SDRAM controller bring-up. Writes a seeded
//             pattern over an address window. Reads the window back with up
//             to MAX_PENDING pipelined reads, compares each returned word and
//             reports pass/fail with an error count and the first bad address.
//  Ports    : clk, reset_n (sync, active-low)
//             start, base_addr, word_count, seed    - test request
//             az_addr/az_be_n/az_cs/az_data/az_rd_n/az_wr_n  - Avalon command
//             za_data/za_valid/za_waitrequest                - Avalon response
//             busy, done, pass, error_count, first_err_addr  - status
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_avalon_tester #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] az_addr,
    output logic [1:0]        az_be_n,
    output logic              az_cs,
    output logic [DATA_W-1:0] az_data,
    output logic              az_rd_n,
    output logic              az_wr_n,
    input  logic [DATA_W-1:0] za_data,
    input  logic              za_valid,
    input  logic              za_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int                OUT_W      = $clog2(MAX_PENDING + 1);
    localparam logic [OUT_W-1:0]  C_MAX_PEND = OUT_W'(MAX_PENDING);
    localparam logic [OUT_W-1:0]  C_OUT_ONE  = OUT_W'(1);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
    localparam logic [15:0]       C_ERR_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_seed;
    logic [ADDR_W-1:0] r_idx;        // command index within the window
    logic [ADDR_W-1:0] r_resp_idx;   // response index within the window
    logic [OUT_W-1:0]  r_outstanding;
    logic [15:0]       r_error_count;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              r_pass;

    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_last_idx;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_resp_addr;
    logic              w_valid_ok;
    logic              w_resp_take;
    logic              w_mismatch;
    logic [OUT_W-1:0]  w_out_next;

    // Low DATA_W bits of the address (zero-extended when the address is
    // narrower than the data word) XORed with the seed.
    function automatic logic [DATA_W-1:0] f_pattern(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] sd
    );
        logic [ADDR_W+DATA_W-1:0] ext;
        ext = {{DATA_W{1'b0}}, addr};
        return ext[DATA_W-1:0] ^ sd;
    endfunction

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    assign w_cmd_addr  = r_base + r_idx;
    assign w_resp_addr = r_base + r_resp_idx;
    assign w_last_idx  = (r_idx == (r_count - C_ADDR_ONE));

    assign w_wr_req    = (r_state == S_WRITE);
    assign w_rd_req    = (r_state == S_READ) && (r_outstanding < C_MAX_PEND);
    assign w_wr_accept = w_wr_req && !za_waitrequest;
    assign w_rd_accept = w_rd_req && !za_waitrequest;

    // A beat counts only while reads are actually in flight; beats arriving
    // in other states (e.g. left over from before a reset) are dropped.
    assign w_valid_ok  = za_valid && (r_outstanding != '0) &&
                         ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_resp_take = w_valid_ok && (r_resp_idx < r_count);
    assign w_mismatch  = w_resp_take && (za_data != f_pattern(w_resp_addr, r_seed));

    // Next-state, next-outstanding and Avalon/status outputs.
    always_comb begin
        w_next_state   = r_state;
        w_out_next     = r_outstanding;
        az_cs          = 1'b0;
        az_rd_n        = 1'b1;
        az_wr_n        = 1'b1;
        az_be_n        = 2'b11;
        az_addr        = '0;
        az_data        = '0;
        busy           = 1'b0;
        done           = 1'b0;
        pass           = r_pass;
        error_count    = r_error_count;
        first_err_addr = r_first_err_addr;

        // Simultaneous accept and return leave the count unchanged.
        if (w_rd_accept && !w_valid_ok) begin
            w_out_next = r_outstanding + C_OUT_ONE;
        end else if (!w_rd_accept && w_valid_ok) begin
            w_out_next = r_outstanding - C_OUT_ONE;
        end

        if (w_wr_req || w_rd_req) begin
            az_cs   = 1'b1;
            az_be_n = 2'b00;
            az_addr = w_cmd_addr;
        end
        if (w_wr_req) begin
            az_wr_n = 1'b0;
            az_data = f_pattern(w_cmd_addr, r_seed);
        end
        if (w_rd_req) begin
            az_rd_n = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (word_count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                if (w_wr_accept && w_last_idx) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (w_rd_accept && w_last_idx) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave on the edge that retires the last read.
                if (w_out_next == '0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                pass         = (r_error_count == 16'd0);
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_base           <= '0;
            r_count          <= '0;
            r_seed           <= '0;
            r_idx            <= '0;
            r_resp_idx       <= '0;
            r_outstanding    <= '0;
            r_error_count    <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_outstanding <= w_out_next;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base           <= base_addr;
                        r_count          <= word_count;
                        r_seed           <= seed;
                        r_idx            <= '0;
                        r_resp_idx       <= '0;
                        r_error_count    <= '0;
                        r_first_err_addr <= '0;
                        r_pass           <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_wr_accept) begin
                        r_idx <= w_last_idx ? '0 : (r_idx + C_ADDR_ONE);
                    end
                end
                S_READ: begin
                    if (w_rd_accept) begin
                        r_idx <= r_idx + C_ADDR_ONE;
                    end
                end
                S_DONE: begin
                    r_pass <= (r_error_count == 16'd0);
                end
                default: begin
                end
            endcase

            // Responses only occur in READ/DRAIN, so these never collide with
            // the clears applied on start in IDLE.
            if (w_resp_take) begin
                r_resp_idx <= r_resp_idx + C_ADDR_ONE;
            end
            if (w_mismatch) begin
                if (r_error_count != C_ERR_MAX) begin
                    r_error_count <= r_error_count + 16'd1;
                end
                // The count saturates rather than wrapping, so zero reliably
                // marks "no mismatch seen yet".
                if (r_error_count == 16'd0) begin
                    r_first_err_addr <= w_resp_addr;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_avalon_tester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_avalon_tester
//  Purpose  : Self-checking bench for sdram_avalon_tester with a behavioural
//             Avalon slave (memory, stalls, read latency, corruption).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_avalon_tester;

    localparam int AW   = 22;
    localparam int DW   = 16;
    localparam int MAXP = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_count;
    logic [DW-1:0] seed;
    logic [AW-1:0] az_addr;
    logic [1:0]    az_be_n;
    logic          az_cs;
    logic [DW-1:0] az_data;
    logic          az_rd_n;
    logic          az_wr_n;
    logic [DW-1:0] za_data;
    logic          za_valid;
    logic          za_waitrequest;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   error_count;
    logic [AW-1:0] first_err_addr;

    sdram_avalon_tester #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .az_addr        (az_addr),
        .az_be_n        (az_be_n),
        .az_cs          (az_cs),
        .az_data        (az_data),
        .az_rd_n        (az_rd_n),
        .az_wr_n        (az_wr_n),
        .za_data        (za_data),
        .za_valid       (za_valid),
        .za_waitrequest (za_waitrequest),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    logic [DW-1:0] mem [int];
    bit            corrupt [int];
    resp_t         rq [$];
    logic [AW-1:0] wlog_a [$];
    logic [DW-1:0] wlog_d [$];

    int cyc = 0, wr_acc = 0, rd_acc = 0, pending = 0, max_pending = 0;
    int full_seen = 0, full_viol = 0, proto_viol = 0, stall_viol = 0;
    int latency = 2, wait_pct = 0, stall_left = 0, stall_cycles = 0;
    logic [AW-1:0] stall_addr = '0;
    bit            prev_stalled = 0;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;
    logic          prev_rd, prev_wr;

    always @(negedge clk) begin
        logic          strobe;
        logic [DW-1:0] d;
        cyc++;
        za_valid = 1'b0;
        za_data  = DW'($urandom);
        if (!reset_n) pending = 0;
        strobe = !az_rd_n || !az_wr_n;

        if (reset_n) begin
            if (!az_rd_n && !az_wr_n) proto_viol++;
            if (az_cs !== strobe || az_be_n !== (strobe ? 2'b00 : 2'b11)) proto_viol++;
            if (pending == MAXP) begin
                full_seen++;
                if (!az_rd_n) full_viol++;
            end
            if (prev_stalled && (az_addr !== prev_a || az_data !== prev_d ||
                                 az_rd_n !== prev_rd || az_wr_n !== prev_wr)) stall_viol++;
        end

        if (rq.size() > 0 && rq[0].due <= cyc) begin
            za_valid = 1'b1;
            za_data  = rq[0].data;
            void'(rq.pop_front());
            if (pending > 0) pending--;
        end

        za_waitrequest = 1'b0;
        if (!az_wr_n && stall_left > 0 && az_addr == stall_addr) begin
            za_waitrequest = 1'b1;
            stall_left--;
            stall_cycles++;
        end else if (strobe && wait_pct > 0 && $urandom_range(99) < wait_pct) begin
            za_waitrequest = 1'b1;
        end

        prev_stalled = reset_n && strobe && za_waitrequest;
        prev_a  = az_addr;
        prev_d  = az_data;
        prev_rd = az_rd_n;
        prev_wr = az_wr_n;

        if (reset_n && !za_waitrequest) begin
            if (!az_wr_n) begin
                mem[int'(az_addr)] = az_data;
                wlog_a.push_back(az_addr);
                wlog_d.push_back(az_data);
                wr_acc++;
            end else if (!az_rd_n) begin
                d = mem.exists(int'(az_addr)) ? mem[int'(az_addr)] : '0;
                if (corrupt.exists(int'(az_addr))) d = d ^ 16'h00FF;
                rq.push_back('{d, cyc + latency});
                rd_acc++;
                pending++;
                if (pending > max_pending) max_pending = pending;
            end
        end
    end

    // ---------------- reference model + test runner ----------------
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [DW-1:0] s);
        return a[DW-1:0] ^ s;
    endfunction

    task automatic run_test(input logic [AW-1:0] b, input logic [AW-1:0] cnt,
                            input logic [DW-1:0] s, input int lat, input int wpct,
                            output int done_wait);
        int            w0, r0, exp_err, bad, k;
        logic [AW-1:0] a, exp_first;
        bit            got;
        latency = lat;
        wait_pct = wpct;
        base_addr = b;
        word_count = cnt;
        seed = s;
        w0 = wr_acc;
        r0 = rd_acc;
        wlog_a.delete();
        wlog_d.delete();

        exp_err = 0;
        exp_first = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = AW'(b + AW'(i));
            if (corrupt.exists(int'(a))) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end

        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #1;
        if (cnt != 0) begin
            chk("first_wr_strobe", az_wr_n, 1'b0);
            chk("first_wr_addr", az_addr, b);
            chk("busy_after_start", busy, 1'b1);
        end
        #1 start = 1'b0;

        got = 0;
        done_wait = 0;
        for (k = 0; k < 5000; k++) begin
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
            done_wait++;
        end
        chk("done_seen", got, 1'b1);
        if (got) begin
            chk("pass", pass, (exp_err == 0));
            chk("error_count", error_count, 16'(exp_err));
            chk("first_err_addr", first_err_addr, exp_first);
            chk("busy_at_done", busy, 1'b0);
            @(posedge clk); #1;
            chk("done_pulse_len", done, 1'b0);
            chk("pass_held", pass, (exp_err == 0));
        end
        chk("writes_accepted", wr_acc - w0, int'(cnt));
        chk("reads_accepted", rd_acc - r0, int'(cnt));
        bad = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = AW'(b + AW'(i));
            if (!mem.exists(int'(a)) || mem[int'(a)] !== pat(a, s)) bad++;
        end
        chk("mem_pattern", bad, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            dw, r0, k;
        bit            got, done_seen_after;
        logic [AW-1:0] rb;

        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        seed = '0;
        za_valid = 1'b0;
        za_waitrequest = 1'b0;
        za_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", az_cs, 1'b0);
        chk("rst_rd_n", az_rd_n, 1'b1);
        chk("rst_wr_n", az_wr_n, 1'b1);
        chk("rst_be_n", az_be_n, 2'b11);
        chk("rst_addr", az_addr, '0);
        chk("rst_data", az_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_errcnt", error_count, 16'd0);
        chk("rst_first", first_err_addr, '0);
        #1 reset_n = 1'b1;

        // Basic 3-word test.
        run_test('0, 3, 16'h0036, 2, 0, dw);
        chk("wlog_size", wlog_d.size(), 3);
        if (wlog_d.size() == 3) begin
            chk("wdata0", wlog_d[0], 16'h0036);
            chk("wdata1", wlog_d[1], 16'h0037);
            chk("wdata2", wlog_d[2], 16'h0034);
            chk("waddr0", wlog_a[0], 22'd0);
            chk("waddr1", wlog_a[1], 22'd1);
            chk("waddr2", wlog_a[2], 22'd2);
        end

        // Waitrequest held for 5 cycles on the second write.
        stall_addr = 22'd1;
        stall_left = 5;
        stall_cycles = 0;
        stall_viol = 0;
        run_test('0, 3, 16'hA5C3, 2, 0, dw);
        chk("stall_cycles", stall_cycles, 5);
        chk("stall_hold", stall_viol, 0);

        // 10-cycle read latency, 16 words: pending limit must be exercised.
        max_pending = 0;
        full_seen = 0;
        full_viol = 0;
        run_test('0, 16, 16'h1234, 10, 0, dw);
        chk("max_pending", max_pending, MAXP);
        chk("pending_limit_hit", (full_seen > 0), 1'b1);
        chk("rd_while_full", full_viol, 0);

        // Corrupted word at address 5.
        corrupt.delete();
        corrupt[5] = 1;
        run_test('0, 8, DW'($urandom), 3, 0, dw);
        corrupt.delete();

        // Start while busy, then reset mid-READ; corrupt the window so any
        // stray beat that got compared would show up in error_count.
        for (int i = 0; i < 16; i++) corrupt[32'h100 + i] = 1;
        latency = 10;
        wait_pct = 0;
        base_addr = 22'h100;
        word_count = 22'd16;
        seed = 16'h5A5A;
        r0 = rd_acc;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        got = 0;
        for (k = 0; k < 500; k++) begin
            if (rd_acc - r0 >= 3) begin
                got = 1;
                break;
            end
            @(posedge clk); #2;
        end
        chk("reached_read", got, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_ignores_start", busy, 1'b1);
        chk("no_write_restart", az_wr_n, 1'b1);
        #1 start = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_rd_n", az_rd_n, 1'b1);
        chk("rst_mid_wr_n", az_wr_n, 1'b1);
        chk("rst_mid_cs", az_cs, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        #1 reset_n = 1'b1;
        done_seen_after = 0;
        for (k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) done_seen_after = 1;
        end
        chk("stray_errcnt", error_count, 16'd0);
        chk("stray_first", first_err_addr, '0);
        chk("stray_no_done", done_seen_after, 1'b0);
        chk("stray_busy", busy, 1'b0);
        corrupt.delete();

        // Zero-length window: done immediately after the start edge.
        run_test(22'h55, 0, 16'hFFFF, 2, 0, dw);
        chk("zero_done_latency", dw, 0);

        // Window wrapping across the top of the address space.
        run_test(22'h3FFFFE, 4, 16'h0F0F, 3, 0, dw);
        chk("wrap_wlog_size", wlog_a.size(), 4);
        if (wlog_a.size() == 4) begin
            chk("wrap_a0", wlog_a[0], 22'h3FFFFE);
            chk("wrap_a1", wlog_a[1], 22'h3FFFFF);
            chk("wrap_a2", wlog_a[2], 22'h000000);
            chk("wrap_a3", wlog_a[3], 22'h000001);
        end

        // Randomised windows, latencies, stalls and corruption.
        stall_viol = 0;
        proto_viol = 0;
        for (int t = 0; t < 8; t++) begin
            int cnt;
            rb  = AW'($urandom);
            cnt = $urandom_range(1, 20);
            corrupt.delete();
            for (int i = 0; i < cnt; i++)
                if ($urandom_range(3) == 0) corrupt[int'(AW'(rb + AW'(i)))] = 1;
            run_test(rb, AW'(cnt), DW'($urandom), $urandom_range(1, 8),
                     $urandom_range(0, 40), dw);
        end
        corrupt.delete();
        chk("rand_stall_hold", stall_viol, 0);
        chk("rand_protocol", proto_viol, 0);
        chk("max_pending_bound", (max_pending <= MAXP), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_avalon_tester.md
Name: sdram_avalon_tester

Overview:
- Synthesizable Avalon-MM master that drives the az_*/za_* slave port of the SDRAM controller. It replaces the bench's write/read tasks with hardware.
- Writes a seeded pattern over an address window, reads the window back with pipelined reads, compares the data and reports pass/fail.
- Sits beside the SDRAM controller on the SDRAM clock domain.
- Used for on-board memory bring-up and as a self-checking stimulus source in simulation.

Parameters:
- ADDR_W, 22, width of the word address (matches az_addr).
- DATA_W, 16, width of the data word (matches az_data/za_data).
- MAX_PENDING, 4, maximum number of reads accepted but not yet returned (1..7).

Ports:
- clk  in  1  SDRAM-domain clock. All logic is on its rising edge.
- reset_n  in  1  Reset: synchronous, active-low.
- start  in  1  One-cycle pulse that begins a test. Ignored while busy=1.
- base_addr  in  ADDR_W  First word address of the window. Sampled on start.
- word_count  in  ADDR_W  Number of words in the window. Sampled on start. 0 means no accesses.
- seed  in  DATA_W  Pattern seed. Sampled on start.
- az_addr  out  ADDR_W  Avalon address.
- az_be_n  out  2  Byte enables, active-low. 2'b00 during commands, 2'b11 when idle.
- az_cs  out  1  Chip select. High while a command is presented.
- az_data  out  DATA_W  Write data.
- az_rd_n  out  1  Read strobe, active-low.
- az_wr_n  out  1  Write strobe, active-low.
- za_data  in  DATA_W  Read data.
- za_valid  in  1  Read data valid.
- za_waitrequest  in  1  Slave stall.
- busy  out  1  High from the cycle after an accepted start until done.
- done  out  1  One-cycle pulse at test end.
- pass  out  1  Result of the last test. Valid from done onward, held until the next start.
- error_count  out  16  Number of mismatching words. Saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  Address of the first mismatch. Holds 0 if there was none.

Behaviour:
- Reset values: az_cs=0, az_rd_n=1, az_wr_n=1, az_be_n=2'b11, az_addr=0, az_data=0, busy=0, done=0, pass=0, error_count=0, first_err_addr=0.
- Reset values also apply to all internal counters. The FSM returns to IDLE.
- Reset asserted mid-test: commands are dropped at the next edge. In-flight za_valid beats are ignored after reset.
- Pattern: expected(a) = a[DATA_W-1:0] XOR seed, with a[DATA_W-1:0] zero-extended if ADDR_W < DATA_W.
- Avalon rule: a command is accepted on an edge where (rd_n=0 or wr_n=0) and za_waitrequest=0. While waitrequest=1, addr, data, strobes and cs are held unchanged.
- At most one command per cycle. Read and write are never asserted together.
- FSM states:
  - IDLE: start=1 latches base/count/seed, clears error_count and first_err_addr, and sets busy. Goes to WRITE, or to DONE_ST if word_count=0.
  - WRITE: presents write index i (addr = base+i, data = expected). On accept, i increments. The accept of the last write goes to READ with i=0. Strobe stays low back-to-back; there is no idle cycle between accepted writes.
  - READ: presents read index i only when outstanding < MAX_PENDING; otherwise strobes are deasserted that cycle. On accept, i and outstanding increment. The accept of the last read goes to DRAIN.
  - DRAIN: waits for outstanding = 0, then goes to DONE_ST.
  - DONE_ST: for one cycle, done=1, busy=0, pass=(error_count==0). Next state is IDLE.
- outstanding counter:
  - increments on each accepted read and decrements on each za_valid.
  - If both occur in the same edge, the count is unchanged.
  - za_valid with outstanding=0 is ignored and never underflows.
- Response tracking: responses return in order. A response index r increments on each za_valid while r < word_count.
  - The response is compared to expected(base+r).
  - On mismatch, error_count increments (saturating). first_err_addr = base+r, but only on the first mismatch.
  - za_valid may arrive in READ or DRAIN, and the compare is identical in both states.
- Address arithmetic is modulo 2^ADDR_W. A window crossing the top wraps to 0 silently.
- Latency:
  - The first write strobe appears on the edge after start is accepted.
  - done appears one cycle after the edge that retires the last outstanding read.

Test Plan:
- Reset, then start with base=0, count=3, seed=16'h0036, waitrequest=0 and the controller/model attached. Writes 0x0036, 0x0037, 0x0034 go to addresses 0..2. Read-back follows, then a done pulse with pass=1 and error_count=0.
- Hold za_waitrequest=1 for 5 cycles during the second write. az_addr=1, az_data and az_wr_n=0 stay stable throughout, and exactly 3 writes are accepted.
- Slave model with 10-cycle read latency and count=16. Outstanding reads never exceed 4, rd_n deasserts when 4 are pending, and all 16 responses are checked.
- Corrupt the model word at address 5 with base=0, count=8. Result is pass=0, error_count=1, first_err_addr=5.
- Pulse start while busy, then pulse reset_n=0 mid-READ. The second start is ignored. After reset, strobes deassert on the next edge, busy=0, and later stray za_valid beats leave error_count at 0.
- start with count=0. done occurs 1 cycle later with pass=1 and no az strobes. Separately, base=22'h3FFFFE with count=4 wraps addresses to 0 and 1.
